// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = serial_arith_pkg::DEFAULT_WIDTH
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             diff_valid;
  logic             diff_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  // Producer/consumer side: supplies operands and accepts results.
  modport master (
    output start_valid, a, b, bin, diff_ready,
    input  start_ready, diff_valid, diff, bout, busy
  );

  // Subtractor side.
  modport slave (
    input  start_valid, a, b, bin, diff_ready,
    output start_ready, diff_valid, diff, bout, busy
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout set when it borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin computed LSB-first, one bit per clock.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt;
  logic             borrow_q;
  logic             bout_q;
  logic             start_ready_q;
  logic             diff_valid_q;
  logic             busy_q;
  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Control FSM and serial datapath; diff_q doubles as the result shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_sr          <= '0;
      b_sr          <= '0;
      diff_q        <= '0;
      cnt           <= '0;
      borrow_q      <= 1'b0;
      bout_q        <= 1'b0;
      start_ready_q <= 1'b1;
      diff_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_sr          <= bus.a;
            b_sr          <= bus.b;
            borrow_q      <= bus.bin;
            cnt           <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          diff_q   <= {cell_d, diff_q[WIDTH-1:1]};
          borrow_q <= cell_bout;
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bout_q       <= cell_bout;
            diff_valid_q <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (bus.diff_ready) begin
            diff_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          start_ready_q <= 1'b1;
          diff_valid_q  <= 1'b0;
          busy_q        <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.diff_valid  = diff_valid_q;
  assign bus.diff        = diff_q;
  assign bus.bout        = bout_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor, the inverse companion to the combinational full adder cell. It accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake. It computes a - b - bin LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. The result is then presented on a valid/ready output handshake. It is intended as an area-cheap arithmetic unit for slow datapaths and as a cross-check against the adder.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
start_valid  input  1  operands a, b, bin valid.
start_ready  output  1  block can accept operands.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow-in.
diff_valid  output  1  result valid.
diff_ready  input  1  consumer accepts result.
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, start_ready=1, diff_valid=0, diff=0, bout=0, busy=0. The borrow register, bit counter and operand shift registers are cleared.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1, the block latches a and b into shift registers, loads bin into the borrow register, clears the bit counter and moves to RUN. This edge is the acceptance edge.
- RUN:
  - start_ready=0 and busy=1.
  - Each edge feeds the LSBs of the a/b shift registers and the borrow register into full_subtractor.
  - The difference bit is shifted into the MSB of the diff register (right shift), so after WIDTH edges bit 0 lands in diff[0].
  - The cell's borrow-out replaces the borrow register, the operand registers shift right, and the counter increments.
  - On the edge where counter == WIDTH-1, the block moves to DONE and copies the final borrow to bout.
- DONE:
  - diff_valid=1; diff and bout are held stable.
  - On an edge with diff_ready=1, the block returns to IDLE and clears diff_valid; diff and bout keep their last values.
- Latency: diff_valid is first high in the cycle following the edge WIDTH edges after the acceptance edge.
- Throughput: one operation per WIDTH+2 cycles minimum. There is a one-cycle IDLE bubble between operations; start_ready is never high in DONE.
- Backpressure: if diff_ready stays low, DONE holds indefinitely with outputs stable.
- start_valid outside IDLE is ignored and must not corrupt operands. Operand inputs are don't-care except on the acceptance edge.
- rst_n low on any edge, including mid-RUN or in DONE, forces the reset values on that edge. Any partial result is discarded and no diff_valid is produced for it.
- Counter width: $clog2(WIDTH). No arithmetic wider than 1 bit outside the cell.

Decomposition:
- Shared package serial_arith_pkg:
  - state typedef (IDLE, RUN, DONE).
  - DEFAULT_WIDTH = 8.
- One sub-module, full_subtractor: combinational, ports a, b, bin -> d, bout.
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~a & bin) | (b & bin).
  - It gets its own exhaustive 8-vector bench, mirroring the full adder bench.

Test Plan:
1. WIDTH=8; a=8'h5A, b=8'h3C, bin=0, diff_ready=1 -> diff=8'h1E, bout=0. diff_valid high exactly 8 edges after acceptance, for one cycle.
2. a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0.
3. Backpressure: a=8'hF0, b=8'h0F, diff_ready held low 5 cycles after diff_valid:
   - diff=8'hE1, bout=0 stable throughout; start_ready=0; a concurrent start_valid is ignored.
   - Handshake completes on the first edge with diff_ready=1.
4. Reset mid-run: accept a=8'hAA, b=8'h55, drop rst_n for one edge after 3 RUN edges:
   - Outputs return to reset values; diff_valid never rises for that operation.
   - A following a=8'h10, b=8'h01 yields diff=8'h0F, bout=0.
5. Back-to-back: start_valid held high with diff_ready=1 -> second acceptance occurs exactly 2 edges after the first result's diff_valid rises (DONE, IDLE bubble). Both results are correct.
6. Random: 1000 random a, b, bin, with diff_ready randomly stalled. A scoreboard checks {bout, diff} against the reference model {a < b+bin, (a-b-bin) mod 256}.
